muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the HI/LO path of the pipeline. It sits in EX, directly upstream of the HI/LO forwarding logic. It accepts MULT/MULTU/DIV/DIVU operands and runs a fixed number of iterations. When finished, it presents a 64-bit result and a one-cycle write strobe, which the pipeline carries as multWr alongside the HI/LO values. While busy, it stalls the front end.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each WIDTH bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: operation request. Sampled only in IDLE.
- `op` input 2: operation. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input WIDTH: rs operand; multiplicand or dividend.
- `b` input WIDTH: rt operand; multiplier or divisor.
- `flush` input 1: abort the in-flight operation with no write.
- `busy` output 1: high while an operation is in flight, including the DONE cycle.
- `done` output 1: one-cycle strobe, driven to the EX-stage multWr.
- `hi_out` output WIDTH: product high word or remainder. Valid when `done`=1 and held until the next accepted `start`.
- `lo_out` output WIDTH: product low word or quotient. Same validity as `hi_out`.

## Operation
- States:
  - IDLE: `start`=1 latches `op`, |a|, |b|, and the sign flags, then goes to RUN with counter=0.
  - RUN: one iteration per cycle. After counter reaches WIDTH-1, go to FIX.
  - FIX: apply sign correction, load `hi_out`/`lo_out`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Multiply: shift-add on a 2·WIDTH accumulator.
  - Signed (MULT): multiply magnitudes, then negate the 64-bit product if sign(a)≠sign(b).
- Divide: restoring divide on the magnitudes, one quotient bit per cycle.
  - Signed (DIV): quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - −2^31 / −1 gives lo=0x8000_0000, hi=0. This is natural WIDTH-bit wrap, with no trap.
- Divide by zero (b=0): the iteration runs normally. The result is fixed at lo=all-ones and hi=a (unsigned view of the original dividend), regardless of signedness.
- `start` outside IDLE is ignored; no queueing. Upstream must hold the instruction while `busy`=1.
- `flush`:
  - In RUN or FIX: return to IDLE next cycle. No `done`; `hi_out`/`lo_out` keep their old values.
  - In DONE: ignored, because the write has already been issued.
  - When `flush` and `start` are both asserted in IDLE, `flush` wins and nothing is accepted.
- Unsigned ops use operands as-is, with no magnitude step.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, counter=0.
- Start accepted at edge T, so `busy`=1 from T+1.
- RUN occupies cycles T+1..T+WIDTH, FIX is T+WIDTH+1, and DONE is T+WIDTH+2.
- Total latency is WIDTH+2 cycles from acceptance to `done`: 34 for WIDTH=32.
- `busy` falls at T+WIDTH+3. A new `start` can be accepted at that edge (back-to-back issue).
- `rst` mid-operation: IDLE at the next edge with all outputs at reset values. No `done` is emitted.
- `hi_out`/`lo_out` change only on the FIX→DONE edge.

## Structure
- Shared package `muldiv_pkg` holds:
  - `op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - state enum (IDLE, RUN, FIX, DONE).
  - `ITER` = WIDTH and the counter width $clog2(WIDTH).
- One natural sub-module, `muldiv_step`: a combinational single iteration. It takes the accumulator, divisor/multiplicand, and mode, and returns the next accumulator. The top block owns the FSM, counter, sign handling, and output registers.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` exactly 34 cycles after start; hi=0xFFFF_FFFE, lo=0x0000_0001; `busy` high 34 cycles.
- MULT a=0xFFFF_FFFD (−3), b=7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (−21). Also −1·−1 → hi=0, lo=1.
- DIV a=−7, b=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIVU 100/7 → lo=14, hi=2. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU and DIV with b=0, a=0x1234 → lo=0xFFFF_FFFF, hi=0x1234. No hang; `done` at 34 cycles.
- `flush` at RUN cycle 10 → no `done`; outputs unchanged from the previous result; `busy`=0 next cycle. `start` held during RUN is ignored.
- `rst` at RUN cycle 20 → all outputs 0 next cycle. Then start immediately after a `done` (back-to-back) → second `done` 34 cycles after its acceptance.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a {hi,lo} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] diff_s;

    // Multiply adds into the high half then shifts right; divide shifts left and trial-subtracts.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        trial_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s   = trial_s - {1'b0, operand};
        acc_next = {(2*WIDTH){1'b0}};
        if (div_mode) begin
            if (!diff_s[WIDTH]) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum_s, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO; one iteration per cycle, WIDTH+2 cycle latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   a_orig_r;
    logic               div_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic               b_zero_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] fix_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .operand  (opnd_r),
        .div_mode (div_r),
        .acc_next (acc_next_s)
    );

    // Operand magnitudes; signed ops (MULT, DIV) are the ones with op[0] clear.
    always_comb begin
        a_neg_s = ~op[0] & a[WIDTH-1];
        b_neg_s = ~op[0] & b[WIDTH-1];
        a_mag_s = a_neg_s ? (~a + ONE_W) : a;
        b_mag_s = b_neg_s ? (~b + ONE_W) : b;
    end

    // Sign correction of the raw accumulator; divide-by-zero overrides with a fixed pattern.
    always_comb begin
        fix_s = acc_r;
        if (div_r) begin
            if (b_zero_r) begin
                fix_s = {a_orig_r, {WIDTH{1'b1}}};
            end else begin
                fix_s[2*WIDTH-1:WIDTH] = neg_hi_r ? (~acc_r[2*WIDTH-1:WIDTH] + ONE_W)
                                                  : acc_r[2*WIDTH-1:WIDTH];
                fix_s[WIDTH-1:0]       = neg_lo_r ? (~acc_r[WIDTH-1:0] + ONE_W)
                                                  : acc_r[WIDTH-1:0];
            end
        end else begin
            fix_s = neg_lo_r ? (~acc_r + ONE_2W) : acc_r;
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            a_orig_r <= {WIDTH{1'b0}};
            div_r    <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            b_zero_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && !flush) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                        div_r    <= op[1];
                        a_orig_r <= a;
                        b_zero_r <= (b == {WIDTH{1'b0}});
                        neg_lo_r <= a_neg_s ^ b_neg_s;
                        neg_hi_r <= a_neg_s;
                        // Multiply iterates over b in the low half; divide shifts the dividend out of it.
                        acc_r    <= {{WIDTH{1'b0}}, op[1] ? a_mag_s : b_mag_s};
                        opnd_r   <= op[1] ? b_mag_s : a_mag_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        acc_r <= acc_next_s;
                        if (cnt_r == LAST_CNT) begin
                            state_r <= FIX;
                            cnt_r   <= {CW{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        hi_r    <= fix_s[2*WIDTH-1:WIDTH];
                        lo_r    <= fix_s[WIDTH-1:0];
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue, compared at done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        int          sx;
        int          sy;
        longint      p;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = x;
        sy = y;
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'b00: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op at the current negedge, hold start for 'hold' extra cycles, then check result and timing.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string tag, input int hold);
        int          lat;
        int          bcnt;
        bit          seen;
        logic [63:0] got;
        logic [63:0] want;
        sb_q.push_back(exp);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        seen = done;
        check_eq({tag, "_busy_rise"}, {63'h0, busy}, 64'h1);
        if (hold == 0) start = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat > hold) start = 1'b0;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, {63'h0, seen}, 64'h1);
        got  = {hi_out, lo_out};
        want = sb_q.pop_front();
        check_eq({tag, "_result"}, got, want);
        check_eq({tag, "_latency"}, 64'(lat), 64'd34);
        check_eq({tag, "_busy_cycles"}, 64'(bcnt), 64'd34);
        @(negedge clk);
        check_eq({tag, "_after_done"}, {62'h0, busy, done}, 64'h0);
        check_eq({tag, "_held"}, {hi_out, lo_out}, want);
    endtask

    initial begin
        logic [63:0] prev;
        bit          any_done;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {62'h0, busy, done}, 64'h0);
        check_eq("reset_data", {hi_out, lo_out}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg", 3);
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "mult_m1m1", 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2", 0);
        run_op(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100_7", 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf", 0);
        run_op(OP_DIVU,  32'h0000_1234, 32'h0,         64'h0000_1234_FFFF_FFFF, "divu_by0", 0);
        run_op(OP_DIV,   32'h0000_1234, 32'h0,         64'h0000_1234_FFFF_FFFF, "div_by0", 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0,         64'hFFFF_FFF9_FFFF_FFFF, "div_neg_by0", 0);

        // Flush in RUN cycle 10 with start held high throughout, then flush+start together in IDLE.
        prev  = {hi_out, lo_out};
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd5000;
        b     = 32'd3;
        @(negedge clk);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_ctrl", {62'h0, busy, done}, 64'h0);
        check_eq("flush_data", {hi_out, lo_out}, prev);
        @(negedge clk);
        check_eq("flush_wins", {63'h0, busy}, 64'h0);
        start    = 1'b0;
        flush    = 1'b0;
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check_eq("flush_no_done", {63'h0, any_done}, 64'h0);
        check_eq("flush_keep", {hi_out, lo_out}, prev);

        for (int k = 0; k < 6; k++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (k == 4) ry = ry >> 20;
            run_op(ro, rx, ry, ref_model(ro, rx, ry), $sformatf("rand%0d", k), 0);
        end

        // Reset in RUN cycle 20 clears everything with no done.
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ctrl", {62'h0, busy, done}, 64'h0);
        check_eq("rst_data", {hi_out, lo_out}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_MULT, 32'h8000_0000, 32'h0000_0002, ref_model(OP_MULT, 32'h8000_0000, 32'h2),
               "b2b_first", 0);
        run_op(OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, "b2b_second", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
